uart_tx_fifo: RTL and testbench

Byte-stream consumer placed directly downstream of the sender controller's frame serializer. It buffers the 13-byte command frame (0x52, 0x0C, 0x01, 8 payload bytes, ~checksum, 0x9A), which arrives as single-cycle byte strobes. It then transmits each byte on the UART line as 8N1, LSB first, with no idle gap between buffered bytes. Status outputs let the controller and the board LEDs see the buffer and line state.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/uart_tx_fifo.sv | 132 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and the
// command-frame byte constants also used by the receiver-side parser.
package uart_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_START = 2'd1;
  localparam state_t ST_DATA  = 2'd2;
  localparam state_t ST_STOP  = 2'd3;

  localparam logic [7:0] FRAME_HEAD = 8'h52;
  localparam logic [7:0] FRAME_LEN  = 8'h0C;
  localparam logic [7:0] FUNC_WRITE = 8'h01;
  localparam logic [7:0] FRAME_TAIL = 8'h9A;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-stream and status bundle between the frame serializer (master) and the
// buffered UART transmitter (slave).
interface uart_tx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  logic [7:0]    din;
  logic          din_valid;
  logic          tx;
  logic          tx_busy;
  logic          fifo_full;
  logic          fifo_empty;
  logic [ADDR_W:0] fifo_count;
  logic          overflow;

  modport master (
    output din, din_valid,
    input  tx, tx_busy, fifo_full, fifo_empty, fifo_count, overflow
  );

  modport slave (
    input  din, din_valid,
    output tx, tx_busy, fifo_full, fifo_empty, fifo_count, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter; writes while full are
// dropped and latch a sticky overflow flag.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             wr_en, rd_en;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign rdata_o    = mem_q[rd_ptr_q];

  // Acceptance uses the status registered before the edge, so a same-edge pop
  // never frees room for a write that arrived while full.
  assign wr_en = push_i && !full_o;
  assign rd_en = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_i & full_o);
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage has no reset; count_q gates every read, so stale data is never used.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: queues serializer bytes and sends them LSB
// first back-to-back, with no idle gap between buffered characters.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int TW     = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          pop, bit_done;
  logic [7:0]    head;
  logic          fifo_full, fifo_empty;
  logic [ADDR_W:0] fifo_count;
  logic          overflow;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (bus.din_valid),
    .wdata_i    (bus.din),
    .pop_i      (pop),
    .rdata_o    (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .overflow_o (overflow)
  );

  assign bit_done       = (timer_q == BIT_LAST);
  assign bus.tx         = tx_q;
  assign bus.tx_busy    = (state_q != ST_IDLE) || !fifo_empty;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_empty = fifo_empty;
  assign bus.fifo_count = fifo_count;
  assign bus.overflow   = overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = ST_DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          timer_d = '0;
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          timer_d = '0;
          // Chain straight into the next start bit when more bytes are waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_q[0];
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a line monitor decodes every character
// and compares it against a scoreboard filled as bytes are written.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   rx_cnt = 0;
  int   fall_cnt = 0;
  logic tx_prev = 1'b1;
  bit   mon_en = 1'b1;

  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_prev && !bus.tx) fall_cnt <= fall_cnt + 1;
    tx_prev <= bus.tx;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Drives one write strobe at a negedge; returns at the negedge after the write edge.
  task automatic push(input logic [7:0] b, input bit accept);
    bus.din       = b;
    bus.din_valid = 1'b1;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  task automatic wait_chars(input int n, input int budget);
    int b;
    b = 0;
    while (rx_cnt < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    check("rx_timeout", 32'(rx_cnt >= n), 1);
  endtask

  // Line monitor: checks all 40 samples of each character against the expected byte.
  initial begin
    logic [7:0] exp_b;
    logic [9:0] fb;
    logic [9:0] got;
    int         line_err;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && bus.tx == 1'b0) begin
        start_q.push_back(cyc);
        check("sb_nonempty", 32'(exp_q.size() != 0), 1);
        exp_b    = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
        fb       = {1'b1, exp_b, 1'b0};
        got      = '0;
        line_err = 0;
        for (int k = 0; k < 10 * CPB; k++) begin
          if (k > 0) @(negedge clk);
          if (bus.tx !== fb[k / CPB]) line_err++;
          if (k % CPB == CPB / 2) got[k / CPB] = bus.tx;
        end
        check("char", {24'd0, got[8:1]}, {24'd0, exp_b});
        check("line_bits", line_err, 0);
        rx_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] frame [13];
    int t0, rx0, peak, bad, fc;

    bus.din       = 8'h00;
    bus.din_valid = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx",       bus.tx, 1);
    check("rst_busy",     bus.tx_busy, 0);
    check("rst_full",     bus.fifo_full, 0);
    check("rst_empty",    bus.fifo_empty, 1);
    check("rst_count",    bus.fifo_count, 0);
    check("rst_overflow", bus.overflow, 0);

    // Single byte: latency, bit pattern, busy release.
    start_q.delete();
    push(8'hA5, 1);
    t0 = cyc;
    repeat (40) @(negedge clk);
    check("t1_busy_stop", bus.tx_busy, 1);
    @(negedge clk);
    check("t1_busy_done", bus.tx_busy, 0);
    wait_chars(1, 200);
    if (start_q.size() > 0) check("t1_latency", start_q[0] - t0, 2);
    else check("t1_latency_seen", 0, 1);

    // Full command frame on 13 consecutive cycles.
    frame = '{FRAME_HEAD, FRAME_LEN, FUNC_WRITE, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h06, FRAME_TAIL};
    repeat (5) @(negedge clk);
    start_q.delete();
    rx0  = rx_cnt;
    peak = 0;
    foreach (frame[i]) begin
      push(frame[i], 1);
      if (int'(bus.fifo_count) > peak) peak = int'(bus.fifo_count);
    end
    check("t2_peak", peak, 12);
    wait_chars(rx0 + 13, 13 * 10 * CPB + 100);
    check("t2_overflow", bus.overflow, 0);
    check("t2_starts", start_q.size(), 13);
    bad = 0;
    for (int i = 1; i < start_q.size(); i++)
      if (start_q[i] - start_q[i-1] != 10 * CPB) bad++;
    check("t2_contiguous", bad, 0);

    // Overflow: one byte in flight, then DEPTH+1 back-to-back writes.
    repeat (5) @(negedge clk);
    rx0 = rx_cnt;
    push(8'h11, 1);
    repeat (5) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) push(8'(8'h22 + i), 1);
    check("t3_full",  bus.fifo_full, 1);
    check("t3_count", bus.fifo_count, DEPTH);
    check("t3_ovf_before", bus.overflow, 0);
    push(8'hEE, 0);
    check("t3_overflow", bus.overflow, 1);
    check("t3_full_after", bus.fifo_full, 1);
    wait_chars(rx0 + DEPTH + 1, (DEPTH + 1) * 10 * CPB + 100);
    check("t3_ovf_sticky", bus.overflow, 1);
    check("t3_drained", bus.fifo_empty, 1);

    // Reset during DATA bit 3 of 0xF0 with three bytes queued.
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    push(8'hF0, 0);
    t0 = cyc;
    push(8'h01, 0);
    push(8'h02, 0);
    push(8'h03, 0);
    repeat (15) @(negedge clk);
    check("t4_bit3", bus.tx, 0);
    check("t4_queued", bus.fifo_count, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_tx",       bus.tx, 1);
    check("t4_count",    bus.fifo_count, 0);
    check("t4_empty",    bus.fifo_empty, 1);
    check("t4_overflow", bus.overflow, 0);
    fc = fall_cnt;
    repeat (200) @(negedge clk);
    check("t4_no_start", fall_cnt - fc, 0);
    mon_en = 1'b1;

    // Push coinciding with the STOP-to-START pop at count 2.
    repeat (3) @(negedge clk);
    start_q.delete();
    rx0 = rx_cnt;
    push(8'h3C, 1);
    t0 = cyc;
    push(8'hC3, 1);
    push(8'h5A, 1);
    check("t5_count2", bus.fifo_count, 2);
    repeat (38) @(negedge clk);
    check("t5_pre", bus.fifo_count, 2);
    push(8'h96, 1);
    check("t5_same_edge", bus.fifo_count, 2);
    wait_chars(rx0 + 4, 4 * 10 * CPB + 100);
    if (start_q.size() >= 2) check("t5_gap", start_q[1] - start_q[0], 10 * CPB);
    else check("t5_gap_seen", 0, 1);

    // Reset release with no strobes and an undefined data bus.
    rst           = 1'b1;
    bus.din       = 8'hxx;
    bus.din_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
    end
    check("t6_quiet", bad, 0);
    check("t6_empty", bus.fifo_empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
